load_store_sequencer: RTL

Multi-cycle sequencer for the decoded load/store micro-op. It accepts the `ld_st_unit` fields of the micro-code, the ALU-computed address and the rs2 store data. It runs one request/acknowledge transaction on the data-memory port and returns the aligned, extended load data. It stalls the single-cycle core with `busy` until the access retires, and it reports misaligned, illegal and bus-fault exceptions to the trap logic.

---
 rtl/load_store_sequencer_pkg.sv | 57 +++++
 rtl/load_store_sequencer_lane_align.sv | 47 ++++
 rtl/load_store_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/load_store_sequencer_pkg.sv
// Shared types for the load/store sequencer: micro-op field encodings, trap cause,
// FSM state and the request legality check.
package load_store_sequencer_pkg;

   typedef enum logic [2:0] {
      LSU_LD            = 3'd0,
      LSU_LDU           = 3'd1,
      LSU_ST            = 3'd2,
      LSU_FENCE         = 3'd3,
      LSU_FENCEI        = 3'd4,
      LSU_FUNCT_UNKNOWN = 3'd5
   } LoadStoreUnitFuncts;

   typedef enum logic [1:0] {
      LSU_BYTE          = 2'd0,
      LSU_HALF          = 2'd1,
      LSU_WORD          = 2'd2,
      LSU_BYTES_UNKNOWN = 2'd3
   } LoadStoreUnitBytes;

   typedef enum logic [1:0] {
      EXC_NONE       = 2'd0,
      EXC_MISALIGNED = 2'd1,
      EXC_ILLEGAL    = 2'd2,
      EXC_BUS_FAULT  = 2'd3
   } LsuExcCause;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   function automatic logic is_mem_op(input LoadStoreUnitFuncts funct);
      return (funct == LSU_LD) || (funct == LSU_LDU) || (funct == LSU_ST);
   endfunction

   // Illegal is tested before misaligned so it takes priority when both apply.
   function automatic LsuExcCause lsu_check(input LoadStoreUnitFuncts funct,
                                            input LoadStoreUnitBytes  bytes,
                                            input logic [1:0]         addr_lo);
      logic known_funct;
      logic illegal;
      logic misaligned;
      known_funct = is_mem_op(funct) || (funct == LSU_FENCE) || (funct == LSU_FENCEI);
      illegal     = !known_funct ||
                    (is_mem_op(funct) && (bytes == LSU_BYTES_UNKNOWN)) ||
                    ((funct == LSU_LDU) && (bytes == LSU_WORD));
      misaligned  = is_mem_op(funct) &&
                    (((bytes == LSU_HALF) && addr_lo[0]) ||
                     ((bytes == LSU_WORD) && (addr_lo != 2'b00)));
      if (illegal)         return EXC_ILLEGAL;
      else if (misaligned) return EXC_MISALIGNED;
      else                 return EXC_NONE;
   endfunction

endpackage

// File: rtl/load_store_sequencer_lane_align.sv
// Byte-lane handling for the data-memory port: byte enables, store replication,
// and load extraction with sign/zero extension.
module lsu_lane_align
   import load_store_sequencer_pkg::*;
(
   input  LoadStoreUnitBytes bytes,
   input  logic [1:0]        addr_lo,
   input  logic [31:0]       st_data,
   input  logic [31:0]       rdata,
   input  logic              sign_ext,
   output logic [3:0]        be,
   output logic [31:0]       wdata,
   output logic [31:0]       ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      be       = 4'b0000;
      wdata    = st_data;
      ld_data  = rdata;
      case (bytes)
         LSU_BYTE: begin
            be      = 4'b0001 << addr_lo;
            wdata   = {4{st_data[7:0]}};
            ld_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         end
         LSU_HALF: begin
            be      = 4'b0011 << addr_lo;
            wdata   = {2{st_data[15:0]}};
            ld_data = {{16{sign_ext & half_sel[15]}}, half_sel};
         end
         LSU_WORD: begin
            be      = 4'hF;
            wdata   = st_data;
            ld_data = rdata;
         end
         default: begin
            be = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/load_store_sequencer.sv
// Multi-cycle load/store sequencer: one req/ack transaction per micro-op, stalls the
// core via busy, reports misaligned/illegal/bus-fault causes to the trap logic.
//
// state  | meaning
// IDLE   | waiting for en; request fields captured on acceptance
// ACCESS | mem_req high, waiting for ack/err or timeout
// RESP   | done pulse, exception/flush reported, core retires
module load_store_sequencer
   import load_store_sequencer_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 255
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  LoadStoreUnitFuncts funct,
   input  LoadStoreUnitBytes  bytes,
   input  logic [31:0]        addr,
   input  logic [31:0]        st_data,
   output logic               busy,
   output logic               done,
   output logic [31:0]        ld_data,
   output logic               exc,
   output LsuExcCause         exc_cause,
   output logic               fencei_flush,
   output logic               mem_req,
   output logic               mem_we,
   output logic [31:0]        mem_addr,
   output logic [3:0]         mem_be,
   output logic [31:0]        mem_wdata,
   input  logic               mem_ack,
   input  logic [31:0]        mem_rdata,
   input  logic               mem_err
);

   localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

   lsu_state_e         state;
   lsu_state_e         state_next;
   LoadStoreUnitFuncts funct_q;
   LoadStoreUnitBytes  bytes_q;
   logic [31:0]        addr_q;
   logic [31:0]        st_data_q;
   logic [7:0]         tmo_cnt;
   logic               timeout;
   LsuExcCause         req_cause;
   logic [31:0]        ld_ext;

   lsu_lane_align u_lane_align (
      .bytes    (bytes_q),
      .addr_lo  (addr_q[1:0]),
      .st_data  (st_data_q),
      .rdata    (mem_rdata),
      .sign_ext (funct_q == LSU_LD),
      .be       (mem_be),
      .wdata    (mem_wdata),
      .ld_data  (ld_ext)
   );

   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_req   = (state == ST_ACCESS);
   assign req_cause = lsu_check(funct, bytes, addr[1:0]);
   assign timeout   = (tmo_cnt == TMO_LAST);

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) begin
               busy       = 1'b1;
               state_next = (is_mem_op(funct) && (req_cause == EXC_NONE)) ? ST_ACCESS : ST_RESP;
            end
         end
         ST_ACCESS: begin
            busy = 1'b1;
            if (mem_ack || mem_err || timeout) state_next = ST_RESP;
         end
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         funct_q      <= LSU_LD;
         bytes_q      <= LSU_BYTE;
         addr_q       <= '0;
         st_data_q    <= '0;
         mem_we       <= 1'b0;
         tmo_cnt      <= '0;
         done         <= 1'b0;
         exc          <= 1'b0;
         exc_cause    <= EXC_NONE;
         fencei_flush <= 1'b0;
         ld_data      <= '0;
      end else begin
         state        <= state_next;
         done         <= 1'b0;
         exc          <= 1'b0;
         exc_cause    <= EXC_NONE;
         fencei_flush <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en) begin
                  funct_q   <= funct;
                  bytes_q   <= bytes;
                  addr_q    <= addr;
                  st_data_q <= st_data;
                  mem_we    <= (funct == LSU_ST);
                  tmo_cnt   <= '0;
                  if (state_next == ST_RESP) begin
                     done         <= 1'b1;
                     exc          <= (req_cause != EXC_NONE);
                     exc_cause    <= req_cause;
                     fencei_flush <= (funct == LSU_FENCEI);
                  end
               end
            end
            ST_ACCESS: begin
               tmo_cnt <= tmo_cnt + 8'd1;
               // Error beats a simultaneous ack; an ack in the last allowed cycle still completes.
               if (mem_err || (!mem_ack && timeout)) begin
                  done      <= 1'b1;
                  exc       <= 1'b1;
                  exc_cause <= EXC_BUS_FAULT;
               end else if (mem_ack) begin
                  done <= 1'b1;
                  if (funct_q != LSU_ST) ld_data <= ld_ext;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
